// File: rtl/deser_pkg.sv
// -----------------------------------------------------------------------------
// deser_pkg
// Shared definitions for the 1-to-8 serial-to-parallel collector.
//   DESER_W       : width of the assembled parallel word
//   IDX_W         : width of the bit index that steers each serial bit
//   deser_state_t : occupancy of the output register (EMPTY / FULL)
//   wr_position() : maps the running bit index to a shadow-byte position,
//                   honouring LSB-first or MSB-first assembly order
// -----------------------------------------------------------------------------
package deser_pkg;

   localparam int DESER_W = 8;
   localparam int IDX_W   = 3;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } deser_state_t;

   // MSB-first assembly writes position 7-idx, which for a 3-bit index is
   // simply the bitwise complement of idx.
   function automatic logic [IDX_W-1:0] wr_position(input logic [IDX_W-1:0] idx,
                                                    input logic             lsb_first);
      return lsb_first ? idx : ~idx;
   endfunction

endpackage : deser_pkg

// File: rtl/decoder_3to8.sv
// -----------------------------------------------------------------------------
// decoder_3to8
// Combinational one-hot decoder: the write-side counterpart of an 8-to-1 bit
// selector. Also usable as a register-file write-enable decoder.
// Ports:
//   sel [2:0] : index of the output bit to assert
//   en        : global enable; when low every output bit is 0
//   out [7:0] : one-hot (or all-zero) write enable
// -----------------------------------------------------------------------------
module decoder_3to8 (
   input  logic [2:0] sel,
   input  logic       en,
   output logic [7:0] out
);

   always_comb begin
      out = 8'h00;
      if (en) begin
         out = 8'h01 << sel;
      end
   end

endmodule : decoder_3to8

// File: rtl/deser_1to8.sv
// -----------------------------------------------------------------------------
// deser_1to8
// Serial-to-parallel collector. One bit is accepted per input handshake and
// steered through a one-hot write decoder into a shadow byte. When the eighth
// bit is accepted, the full byte (including that bit) moves into the output
// register, which is offered downstream on a valid/ready handshake. Collection
// of the next byte proceeds while the previous one waits.
//
// Handshake semantics (both sides): a transfer happens on a rising clock edge
// where valid and ready are both high. A producer that raises valid keeps its
// data stable until the transfer; ready may be withdrawn at any time.
//
// Parameters:
//   LSB_FIRST : 1 -> first accepted bit lands in out[0]; 0 -> in out[7]
// Ports:
//   clk       : sole clock, rising edge
//   reset     : asynchronous, active-low reset
//   in        : serial data bit
//   in_valid  : in holds a bit this cycle
//   in_ready  : block accepts a bit this cycle (combinational)
//   clear     : synchronous abort of the partial byte
//   out       : completed byte (registered)
//   out_valid : out holds an unconsumed byte (registered)
//   out_ready : consumer takes out this cycle
//   count     : number of bits held in the partial byte (registered)
//   dbg_state : current occupancy state of the output register
// -----------------------------------------------------------------------------
module deser_1to8
   import deser_pkg::*;
#(
   parameter logic LSB_FIRST = 1'b1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               clear,
   output logic [DESER_W-1:0] out,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [IDX_W-1:0]   count,
   output deser_state_t       dbg_state
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DESER_W - 1);

   deser_state_t       r_state;
   logic [IDX_W-1:0]   r_idx;
   logic [DESER_W-1:0] r_shadow;
   logic [DESER_W-1:0] r_out;

   logic               w_accept;
   logic               w_consume;
   logic               w_write;
   logic               w_complete;
   logic [IDX_W-1:0]   w_wr_pos;
   logic [DESER_W-1:0] w_wr_en;
   logic [DESER_W-1:0] w_shadow_nxt;

   // Backpressure only when completing now would overwrite a byte that the
   // consumer is not taking this very cycle.
   assign in_ready  = !((r_state == FULL) && (r_idx == LAST_IDX) && !out_ready);

   assign w_accept  = in_valid && in_ready;
   assign w_consume = out_valid && out_ready;

   // clear discards any concurrent accept, so it also suppresses the write.
   assign w_write    = w_accept && !clear;
   assign w_complete = w_write && (r_idx == LAST_IDX);
   assign w_wr_pos   = wr_position(r_idx, LSB_FIRST);

   decoder_3to8 u_wr_dec (
      .sel (w_wr_pos),
      .en  (w_write),
      .out (w_wr_en)
   );

   // Shadow byte with the incoming bit merged in; only the decoded bit moves.
   always_comb begin
      w_shadow_nxt = r_shadow;
      for (int i = 0; i < DESER_W; i++) begin
         if (w_wr_en[i]) begin
            w_shadow_nxt[i] = in;
         end
      end
   end

   // Index counter, shadow byte and output register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_idx    <= '0;
         r_shadow <= '0;
         r_out    <= '0;
      end else if (clear) begin
         r_idx    <= '0;
         r_shadow <= '0;
      end else if (w_write) begin
         if (w_complete) begin
            r_out    <= w_shadow_nxt;
            r_shadow <= '0;
            r_idx    <= '0;
         end else begin
            r_shadow <= w_shadow_nxt;
            r_idx    <= r_idx + IDX_W'(1);
         end
      end
   end

   // Output-register occupancy. A completion while FULL is only possible
   // when the old byte is being consumed in the same cycle, so the new byte
   // replaces it with no bubble.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= EMPTY;
      end else begin
         case (r_state)
            EMPTY: begin
               if (w_complete) begin
                  r_state <= FULL;
               end
            end
            FULL: begin
               if (w_complete) begin
                  r_state <= FULL;
               end else if (w_consume) begin
                  r_state <= EMPTY;
               end
            end
            default: r_state <= EMPTY;
         endcase
      end
   end

   assign out       = r_out;
   assign out_valid = (r_state == FULL);
   assign count     = r_idx;
   assign dbg_state = r_state;

   // Held output must not change until it is taken.
   a_out_stable : assert property (@(posedge clk) disable iff (!reset)
      (out_valid && !out_ready) |=> $stable(out));

   // The write decoder never enables more than one shadow bit.
   a_wr_onehot : assert property (@(posedge clk) disable iff (!reset)
      $onehot0(w_wr_en));

endmodule : deser_1to8

// File: tb/tb_deser_1to8.sv
// -----------------------------------------------------------------------------
// tb_deser_1to8
// Drives one LSB-first and one MSB-first instance with identical stimulus and
// compares both against a queue-based model of the collector every cycle.
// -----------------------------------------------------------------------------
module tb_deser_1to8;
   import deser_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk       = 1'b0;
   logic reset     = 1'b1;
   logic in        = 1'b0;
   logic in_valid  = 1'b0;
   logic clear     = 1'b0;
   logic out_ready = 1'b0;

   always #5 clk = ~clk;

   logic         in_ready_l, in_ready_m;
   logic [7:0]   out_l, out_m;
   logic         ov_l, ov_m;
   logic [2:0]   cnt_l, cnt_m;
   deser_state_t st_l, st_m;

   deser_1to8 #(.LSB_FIRST(1'b1)) u_lsb (
      .clk(clk), .reset(reset), .in(in), .in_valid(in_valid), .in_ready(in_ready_l),
      .clear(clear), .out(out_l), .out_valid(ov_l), .out_ready(out_ready),
      .count(cnt_l), .dbg_state(st_l)
   );

   deser_1to8 #(.LSB_FIRST(1'b0)) u_msb (
      .clk(clk), .reset(reset), .in(in), .in_valid(in_valid), .in_ready(in_ready_m),
      .clear(clear), .out(out_m), .out_valid(ov_m), .out_ready(out_ready),
      .count(cnt_m), .dbg_state(st_m)
   );

   // ---------------- bookkeeping ----------------
   int n_tests = 0;
   int n_fail  = 0;
   int n_made  = 0;
   int n_taken = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // The partial byte is just the list of bits accepted so far; a byte is
   // assembled from that list only when it is complete.
   bit         m_bits[$];
   logic       m_valid;
   logic [7:0] m_out_lsb;
   logic [7:0] m_out_msb;
   logic [7:0] exp_q[$];
   logic       m_acc, m_cons, m_done;

   function automatic logic [7:0] pack_bits(input logic lsb);
      logic [7:0] v;
      v = 8'h00;
      for (int k = 0; k < 8; k++) begin
         if (lsb) v[k] = m_bits[k];
         else     v[7-k] = m_bits[k];
      end
      return v;
   endfunction

   function automatic logic m_in_ready();
      return !(m_valid && (m_bits.size() == 7) && !out_ready);
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_bits.delete();
         exp_q.delete();
         m_valid   = 1'b0;
         m_out_lsb = 8'h00;
         m_out_msb = 8'h00;
      end else begin
         m_acc  = in_valid && m_in_ready();
         m_cons = m_valid && out_ready;
         m_done = 1'b0;
         if (clear) begin
            m_bits.delete();
         end else if (m_acc) begin
            m_bits.push_back(in);
            if (m_bits.size() == 8) begin
               m_out_lsb = pack_bits(1'b1);
               m_out_msb = pack_bits(1'b0);
               m_bits.delete();
               exp_q.push_back(m_out_lsb);
               n_made++;
               m_done = 1'b1;
            end
         end
         if (m_done)      m_valid = 1'b1;
         else if (m_cons) m_valid = 1'b0;
      end
   end

   // ---------------- compare process / scoreboard ----------------
   always @(negedge clk) begin
      if (reset) begin
         check("in_ready_lsb",  {31'd0, in_ready_l}, {31'd0, m_in_ready()});
         check("in_ready_msb",  {31'd0, in_ready_m}, {31'd0, m_in_ready()});
         check("out_valid_lsb", {31'd0, ov_l}, {31'd0, m_valid});
         check("out_valid_msb", {31'd0, ov_m}, {31'd0, m_valid});
         check("state_lsb",     {31'd0, st_l}, {31'd0, m_valid});
         check("count_lsb",     {29'd0, cnt_l}, 32'(m_bits.size()));
         check("count_msb",     {29'd0, cnt_m}, 32'(m_bits.size()));
         check("out_lsb",       {24'd0, out_l}, {24'd0, m_out_lsb});
         check("out_msb",       {24'd0, out_m}, {24'd0, m_out_msb});
         if (ov_l && out_ready) begin
            n_taken++;
            if (exp_q.size() == 0) begin
               check("sb_unexpected_byte", {24'd0, out_l}, 32'hFFFF_FFFF);
            end else begin
               check("sb_byte", {24'd0, out_l}, {24'd0, exp_q.pop_front()});
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   // Called at posedge+1; returns at posedge+1 after the bit was accepted.
   task automatic send_bit(input logic b);
      logic got;
      got      = 1'b0;
      in       = b;
      in_valid = 1'b1;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (in_ready_l) begin
            got = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
      end
      if (got) begin
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      check("send_bit_accepted", {31'd0, got}, 32'd1);
   endtask

   task automatic send_bits(input logic [7:0] v, input int nbits);
      for (int k = 0; k < nbits; k++) send_bit(v[k]);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- directed + random stimulus ----------------
   int made0, taken0;

   initial begin
      // Reset asserted at time 0 (the 1->0 edge fires the async reset).
      reset = 1'b0;
      #2;
      check("rst_out_valid", {31'd0, ov_l}, 32'd0);
      check("rst_out",       {24'd0, out_l}, 32'h00);
      check("rst_count",     {29'd0, cnt_l}, 32'd0);
      check("rst_in_ready",  {31'd0, in_ready_l}, 32'd1);
      repeat (2) @(posedge clk);
      #1;
      reset     = 1'b1;
      out_ready = 1'b1;
      tick();

      // Stream 1,0,1,1,0,0,1,0 with the consumer always ready.
      send_bits(8'b0100_1101, 8);
      check("t1_out_valid", {31'd0, ov_l}, 32'd1);
      check("t1_out_lsb",   {24'd0, out_l}, 32'h4D);
      check("t1_out_msb",   {24'd0, out_m}, 32'hB2);
      check("t1_count",     {29'd0, cnt_l}, 32'd0);
      tick();
      check("t1_pulse_end", {31'd0, ov_l}, 32'd0);

      // Backpressure: 15 bits with no consumer, 16th held until ready rises.
      out_ready = 1'b0;
      send_bits(8'h13, 8);
      send_bits(8'h5A, 7);
      check("t2_count7",    {29'd0, cnt_l}, 32'd7);
      check("t2_first_msb", {24'd0, out_m}, 32'hC8);
      in       = 1'b0;
      in_valid = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("t2_in_ready_low", {31'd0, in_ready_l}, 32'd0);
         check("t2_out_hold",     {24'd0, out_l}, 32'h13);
         tick();
      end
      out_ready = 1'b1;
      @(negedge clk);
      check("t2_in_ready_high", {31'd0, in_ready_l}, 32'd1);
      tick();
      in_valid = 1'b0;
      check("t2_second_valid", {31'd0, ov_l}, 32'd1);
      check("t2_second_byte",  {24'd0, out_l}, 32'h5A);
      check("t2_count0",       {29'd0, cnt_l}, 32'd0);
      tick();

      // clear after 5 bits, concurrent with a 6th valid bit, byte pending.
      out_ready = 1'b0;
      send_bits(8'hE7, 8);
      send_bits(8'b0000_1011, 5);
      in       = 1'b1;
      in_valid = 1'b1;
      clear    = 1'b1;
      tick();
      in_valid = 1'b0;
      clear    = 1'b0;
      check("t3_count_cleared", {29'd0, cnt_l}, 32'd0);
      check("t3_pending_valid", {31'd0, ov_l}, 32'd1);
      check("t3_pending_byte",  {24'd0, out_l}, 32'hE7);
      out_ready = 1'b1;
      send_bits(8'h6B, 8);
      check("t3_clean_byte", {24'd0, out_l}, 32'h6B);
      tick();

      // Asynchronous reset mid-byte with a pending byte.
      out_ready = 1'b0;
      send_bits(8'h81, 8);
      send_bits(8'h05, 3);
      @(negedge clk);
      #2;
      reset = 1'b0;
      #1;
      check("t4_rst_out_valid", {31'd0, ov_l}, 32'd0);
      check("t4_rst_out",       {24'd0, out_l}, 32'h00);
      check("t4_rst_count",     {29'd0, cnt_l}, 32'd0);
      check("t4_rst_in_ready",  {31'd0, in_ready_l}, 32'd1);
      @(posedge clk);
      #1;
      reset = 1'b1;
      tick();

      // Randomized traffic.
      made0  = n_made;
      taken0 = n_taken;
      for (int c = 0; c < 1000; c++) begin
         in        = 1'($urandom_range(0, 1));
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         clear     = ($urandom_range(0, 39) == 0);
         tick();
      end
      in_valid  = 1'b0;
      clear     = 1'b0;
      out_ready = 1'b1;
      repeat (3) tick();
      check("rand_bytes_made",    {31'd0, (n_made > made0 + 50)}, 32'd1);
      check("rand_none_lost",     32'(n_taken - taken0), 32'(n_made - made0));
      check("rand_queue_drained", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Absolute guard so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule : tb_deser_1to8

// File: doc/deser_1to8.md
# deser_1to8

Serial-to-parallel collector; the receiving end of the 8-to-1 bit-selection path. Bits arrive one per handshake. An internal 3-bit index, driven through a one-hot write decoder, steers each bit into position 0..7 of a shadow byte. A completed byte transfers to an output register presented with a valid/ready handshake, so collection of the next byte continues while the previous one waits.

## Interface
Parameters:
- `LSB_FIRST`, 1, 1: first accepted bit lands in `out[0]`; 0: first bit lands in `out[7]`.

Ports:
- `clk`  input  1  sole clock; all state on rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `in`  input  1  serial data bit.
- `in_valid`  input  1  `in` holds a bit this cycle.
- `in_ready`  output  1  block accepts a bit this cycle.
- `clear`  input  1  synchronous abort of the partial byte.
- `out`  output  8  completed byte.
- `out_valid`  output  1  `out` holds an unconsumed byte.
- `out_ready`  input  1  consumer takes `out` this cycle.
- `count`  output  3  bits held in the partial byte (index register).

## Operation
- Accept event: `in_valid && in_ready`. Consume event: `out_valid && out_ready`.
- Index `idx` (3 bits) selects the write position.
  - Position is `idx` when `LSB_FIRST=1`, else `7-idx`.
  - Decoder produces a one-hot 8-bit write enable, gated by the accept event. Only the selected shadow bit updates.
- On accept, `idx` increments modulo 8. Accept at `idx==7` completes the byte:
  - the full shadow byte, including the bit being written, loads into the `out` register;
  - `out_valid` sets;
  - `idx` wraps to 0;
  - shadow clears to 0.
- State machine (2 states):
  - EMPTY: `out_valid=0`.
  - FULL: `out_valid=1`.
  - EMPTY→FULL on completion.
  - FULL→EMPTY on consume without completion.
  - FULL→FULL on consume and completion in the same cycle: the new byte replaces the old; no loss, no bubble.
- `in_ready` = `!(state==FULL && idx==7 && !out_ready)`. Backpressure applies only when a completion would overwrite an unconsumed byte.
- `clear` (same cycle as accept or not):
  - `idx`←0 and shadow←0; any concurrent accept is discarded.
  - Does not affect `out`, `out_valid`, or the consume event.
- `out` is stable while `out_valid=1` and `out_ready=0`.
- `count` = `idx`.

## Timing
- Reset values: `out`=8'h00, `out_valid`=0, `count`=0, shadow=0, state EMPTY. `in_ready` is 1 during and after reset.
- Reset mid-byte discards partial and pending bytes immediately, without waiting for a clock.
- Latency: `out_valid` rises the cycle after the 8th accept edge. Minimum byte period is 8 cycles; sustained throughput is 1 bit/cycle with `out_ready` held high.
- `in_ready` is combinational from state, `idx`, and `out_ready`. It is the only input-to-output combinational path.
- `out_valid`, `out`, and `count` are registered outputs.

## Structure
- Package `deser_pkg`:
  - `localparam DESER_W = 8` and `IDX_W = 3`;
  - typedef enum `deser_state_t {EMPTY, FULL}`.
- Sub-module `decoder_3to8`: combinational, inputs `sel[2:0]` and `en`, output `out[7:0]` one-hot (all zero when `en=0`). It is the write-side counterpart of the 8-to-1 selector and is reusable for register-file write enables.
- Top level contains the index counter, shadow register, output register, and FSM.

## Test plan
- Reset, then feed bits 1,0,1,1,0,0,1,0 (`LSB_FIRST=1`, `out_ready=1`) → `out_valid` pulses 1 cycle after the 8th accept, `out`=8'h4D, `count` returns to 0.
- Same stream with `LSB_FIRST=0` → `out`=8'hB2.
- `out_ready=0`, stream 16 bits continuously → first byte held stable; `in_ready` drops exactly when `count==7`; raising `out_ready` gives a same-cycle consume and completion, and the second byte appears next cycle with no lost bits.
- Pulse `clear` after 5 accepted bits, concurrent with a 6th `in_valid` → `count`=0, that bit dropped; the next 8 bits form a clean byte; a previously pending `out` is unaffected.
- Drop `reset` mid-byte with `out_valid=1` → `out_valid`, `out`, and `count` go to 0 immediately, without a clock edge; `in_ready`=1.
- Randomized `in_valid`/`out_ready` over 1000 cycles against a reference queue → every byte matches, none is lost or duplicated.
